// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one-at-a-time imem requests,
// and buffers returned words in a 2-entry FIFO handed to decode via valid/ready.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect,
  input  logic [31:0] npc,
  output logic [31:0] pc_add4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        id_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_pc;
  logic [31:0] last_pc;
  logic        drop, drop_nxt;
  logic [1:0]  count;
  logic        rd_ptr, wr_ptr;
  logic [31:0] fifo_pc   [0:1];
  logic [31:0] fifo_inst [0:1];
  logic        grant, push, pop, flush, capture;

  // Requests are withheld while the FIFO is full, so a response always has a slot.
  assign imem_req  = (state == REQ) && (count != 2'd2);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  assign if_valid = (count != 2'd0);
  assign pop      = if_valid && id_ready;
  assign if_pc    = if_valid ? fifo_pc[rd_ptr] : last_pc;
  assign if_inst  = if_valid ? fifo_inst[rd_ptr] : NOP_INST;
  assign pc_add4  = if_pc + 32'd4;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    push      = 1'b0;
    capture   = 1'b0;
    flush     = redirect;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (grant) begin
          state_nxt = WAIT;
          capture   = !redirect;
          pc_nxt    = pc + 32'd4;
          drop_nxt  = redirect;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
          push      = !drop && !redirect;
          drop_nxt  = 1'b0;
        end else if (redirect) begin
          drop_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A redirect always wins over the sequential address.
    if (redirect) pc_nxt = npc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= RESET_PC;
      drop    <= 1'b0;
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      last_pc <= RESET_PC;
    end else begin
      pc   <= pc_nxt;
      drop <= drop_nxt;
      if (pop) last_pc <= fifo_pc[rd_ptr];
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) req_pc <= pc;
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_inst[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: the bench plays instruction memory cycle by cycle.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk, rstn, redirect, imem_req, imem_gnt, imem_rvalid, if_valid, id_ready;
  logic [31:0] npc, pc_add4, imem_addr, imem_rdata, if_pc, if_inst;
  int checks = 0;
  int errors = 0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rstn(rstn), .redirect(redirect), .npc(npc), .pc_add4(pc_add4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and advance one edge so the FSM sits in REQ at RESET_PC.
  task automatic start();
    rstn = 1'b0; redirect = 1'b0; npc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b0; redirect = 1'b0; npc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;
    cyc(); cyc();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h want %h", imem_addr, RESET_PC); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    checks++; if (if_pc !== RESET_PC) begin errors++; $display("FAIL rst_pc: got %h want %h", if_pc, RESET_PC); end
    checks++; if (if_inst !== NOP_INST) begin errors++; $display("FAIL rst_inst: got %h want %h", if_inst, NOP_INST); end
    checks++; if (pc_add4 !== 32'h0040_0004) begin errors++; $display("FAIL rst_add4: got %h want 00400004", pc_add4); end
    rstn = 1'b1;
    cyc();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    start();
    for (int i = 0; i < 3; i++) begin
      a = RESET_PC + 32'(4 * i);
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %b want 1", i, imem_req); end
      checks++; if (imem_addr !== a) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, a); end
      imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req[%0d]: got %b want 0", i, imem_req); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_popped[%0d]: got %b want 0", i, if_valid); end
      checks++; if (if_pc !== ((i == 0) ? RESET_PC : a - 32'd4)) begin errors++; $display("FAIL seq_lastpc[%0d]: got %h want %h", i, if_pc, (i == 0) ? RESET_PC : a - 32'd4); end
      imem_rvalid = 1'b1; imem_rdata = dat(a); cyc(); imem_rvalid = 1'b0;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, if_valid); end
      checks++; if (if_pc !== a) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, if_pc, a); end
      checks++; if (if_inst !== dat(a)) begin errors++; $display("FAIL seq_inst[%0d]: got %h want %h", i, if_inst, dat(a)); end
      checks++; if (pc_add4 !== a + 32'd4) begin errors++; $display("FAIL seq_add4[%0d]: got %h want %h", i, pc_add4, a + 32'd4); end
    end
  endtask

  task automatic test_backpressure();
    start(); id_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = dat(RESET_PC + 32'(4 * i)); cyc(); imem_rvalid = 1'b0;
    end
    imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req[%0d]: got %b want 0", i, imem_req); end
      checks++; if (if_pc !== RESET_PC) begin errors++; $display("FAIL bp_head[%0d]: got %h want %h", i, if_pc, RESET_PC); end
      cyc();
    end
    imem_gnt = 1'b0;
    checks++; if (imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL bp_hold_addr: got %h want 00400008", imem_addr); end
    id_ready = 1'b1; cyc();
    checks++; if (if_pc !== 32'h0040_0004) begin errors++; $display("FAIL bp_pop1_pc: got %h want 00400004", if_pc); end
    checks++; if (if_inst !== dat(32'h0040_0004)) begin errors++; $display("FAIL bp_pop1_inst: got %h want %h", if_inst, dat(32'h0040_0004)); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_resume_req: got %b want 1", imem_req); end
    cyc();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", if_valid); end
    checks++; if (imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL bp_resume_addr: got %h want 00400008", imem_addr); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0008); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_pc !== 32'h0040_0008) begin errors++; $display("FAIL bp_third_pc: got %h want 00400008", if_pc); end
  endtask

  task automatic test_back_to_back();
    start(); id_ready = 1'b0;
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(RESET_PC); cyc(); imem_rvalid = 1'b0;
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    id_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0004); cyc(); imem_rvalid = 1'b0;
    id_ready = 1'b0;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h0040_0004) begin errors++; $display("FAIL b2b_pc: got %h want 00400004", if_pc); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b want 1", imem_req); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0008); cyc(); imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_full_req: got %b want 0", imem_req); end
    checks++; if (if_pc !== 32'h0040_0004) begin errors++; $display("FAIL b2b_full_head: got %h want 00400004", if_pc); end
  endtask

  task automatic test_redirect_wait();
    start();
    for (int i = 0; i < 2; i++) begin
      imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = dat(RESET_PC + 32'(4 * i)); cyc(); imem_rvalid = 1'b0;
    end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    redirect = 1'b1; npc = 32'h0040_0100; cyc(); redirect = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_req: got %b want 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0008); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %b want 0", if_valid); end
    checks++; if (if_pc !== 32'h0040_0004) begin errors++; $display("FAIL rw_pc: got %h want 00400004", if_pc); end
    checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL rw_addr: got %h want 00400100", imem_addr); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0100); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_pc !== 32'h0040_0100) begin errors++; $display("FAIL rw_new_pc: got %h want 00400100", if_pc); end
    checks++; if (if_inst !== dat(32'h0040_0100)) begin errors++; $display("FAIL rw_new_inst: got %h want %h", if_inst, dat(32'h0040_0100)); end
  endtask

  task automatic test_redirect_coincident();
    start();
    imem_gnt = 1'b1; redirect = 1'b1; npc = 32'h0040_0200; cyc();
    imem_gnt = 1'b0; redirect = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rg_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL rg_pc: got %h want 00400200", imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = dat(RESET_PC); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rg_dropped: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rg_rereq: got %b want 1", imem_req); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0200); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_pc !== 32'h0040_0200) begin errors++; $display("FAIL rg_new_pc: got %h want 00400200", if_pc); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0204); redirect = 1'b1; npc = 32'h0040_0300; cyc();
    imem_rvalid = 1'b0; redirect = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rr_dropped: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rr_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0300) begin errors++; $display("FAIL rr_addr: got %h want 00400300", imem_addr); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0300); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL rr_new_valid: got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h0040_0300) begin errors++; $display("FAIL rr_new_pc: got %h want 00400300", if_pc); end
  endtask

  task automatic test_ungranted();
    start();
    cyc();
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL ug_stable: got %h want %h", imem_addr, RESET_PC); end
    redirect = 1'b1; npc = 32'h0040_0040; cyc(); redirect = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ug_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0040) begin errors++; $display("FAIL ug_addr: got %h want 00400040", imem_addr); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = dat(32'h0040_0040); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_pc !== 32'h0040_0040) begin errors++; $display("FAIL ug_pc: got %h want 00400040", if_pc); end
    checks++; if (imem_addr !== 32'h0040_0044) begin errors++; $display("FAIL ug_next: got %h want 00400044", imem_addr); end
  endtask

  task automatic test_wrap();
    start();
    redirect = 1'b1; npc = 32'hFFFF_FFFC; cyc(); redirect = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr: got %h want fffffffc", imem_addr); end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wr_next: got %h want 00000000", imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = dat(32'hFFFF_FFFC); cyc(); imem_rvalid = 1'b0;
    checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc: got %h want fffffffc", if_pc); end
    checks++; if (pc_add4 !== 32'h0000_0000) begin errors++; $display("FAIL wr_add4: got %h want 00000000", pc_add4); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wr_req: got %b want 1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_coincident();
    test_ungranted();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage sitting directly downstream of the next-PC mux. It owns the fetch PC register, loads it from the mux's `npc` on a redirect, and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned instructions enter a 2-entry buffer and are handed to decode over a valid/ready interface. It also produces `pc_add4` for the mux from the instruction currently offered to decode.

## Interface
- `RESET_PC`, 32'h0040_0000: fetch address after reset.
- `NOP_INST`, 32'h0000_0013: value of `if_inst` when no instruction is valid.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `redirect`  in  1  taken branch/jump this cycle (mux select != sequential); load `npc`.
- `npc`  in  32  next PC from the next-PC mux.
- `pc_add4`  out  32  `if_pc + 4`, fed back to the mux.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch word address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid; exactly one per grant, at least 1 cycle after it.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  buffer head valid.
- `if_pc`  out  32  PC of buffer head.
- `if_inst`  out  32  instruction at buffer head.
- `id_ready`  in  1  decode accepts the head this cycle.

## Operation
- Registers: `pc` (next fetch address), FSM state, `req_pc` (address of the outstanding request), `drop` flag, and a 2-entry FIFO of {pc, inst} with a count of 0..2.
- FSM states:
  - IDLE: entered on reset; goes to REQ unconditionally on the next edge.
  - REQ: `imem_req=1`, `imem_addr=pc`. Requesting is gated: `imem_req` is 0 while count==2; the FSM stays in REQ.
    - On `imem_gnt`: `req_pc<=pc`, `pc<=pc+4`, go to WAIT.
  - WAIT: `imem_req=0`.
    - On `imem_rvalid` with `drop=0`: push {req_pc, imem_rdata} and go to REQ.
    - On `imem_rvalid` with `drop=1`: discard the data, clear `drop`, go to REQ.
- Credit rule: at most one outstanding request. A grant is only possible while count<=1, so there is always a free slot when the response arrives.
- Pop: `if_valid && id_ready` removes the head. A push and a pop in the same cycle leave the count unchanged.
- Redirect (sampled at the edge, overrides everything else):
  - FIFO is flushed (count<=0).
  - `pc<=npc`.
  - In REQ without a grant: the unissued request is abandoned and the next cycle requests `npc`.
  - In REQ with a grant in the same cycle: go to WAIT with `drop<=1`, and `pc<=npc` (not pc+4).
  - In WAIT: `drop<=1`, except when `imem_rvalid` is high in the same cycle; that response is discarded and the FSM goes to REQ with `drop=0`.
  - In IDLE: `pc<=npc`.
- `imem_addr` is stable from request assertion until grant, except on a redirect; the imem protocol permits abandoning an ungranted request.
- Arithmetic: all PC adds are modulo 2^32; 32'hFFFF_FFFC + 4 = 0. `npc` is used as given; alignment is not checked.
- `pc_add4 = if_pc + 4` combinationally. When `if_valid=0`, `if_pc` holds the last popped or reset value.

## Timing
- Reset (async assert, synchronous release effect), all outputs:
  - `imem_req=0`, `imem_addr=RESET_PC`
  - `if_valid=0`, `if_pc=RESET_PC`, `if_inst=NOP_INST`, `pc_add4=RESET_PC+4`
  - count=0, `drop=0`, state IDLE.
- First request: `imem_req` rises in the 2nd cycle after `rstn` deasserts.
- Fetch latency: grant at edge N, rvalid at edge N+k, `if_valid` high after edge N+k.
- Throughput: 1 instruction per 2 cycles with k=1 (REQ→WAIT→REQ); the FIFO smooths decode stalls.
- Redirect latency: redirect at edge R; request for `npc` is visible after R; `if_valid=0` after R until the new response arrives.
- Reset mid-transaction: all state cleared; any later rvalid for the old grant is the memory's responsibility (imem is reset by the same `rstn`).

## Test plan
- Reset/sequential: release `rstn`, imem grants immediately and rvalid 1 cycle later with data=addr → `imem_addr` 0x00400000, 0x00400004, 0x00400008 in order; `if_pc`/`if_inst` match; `pc_add4` = `if_pc`+4.
- Backpressure: hold `id_ready=0` → exactly 2 instructions buffered, `imem_req` stays low; raise `id_ready` → heads 0x00400000, 0x00400004 are popped in order, then fetching resumes at 0x00400008.
- Redirect in WAIT: redirect with `npc`=0x00400100 while a request for 0x00400008 is outstanding → its response is dropped, the next request is 0x00400100, and `if_pc` never shows 0x00400008.
- Redirect coincident with grant, and coincident with rvalid → neither response is pushed; the fetch stream continues from `npc`.
- Ungranted request: hold `imem_gnt=0` and pulse redirect to 0x00400040 → `imem_addr` switches to 0x00400040 the next cycle and the old address is never granted.
- Wraparound: redirect to 0xFFFFFFFC → next fetch address is 0x00000000; `pc_add4` for head 0xFFFFFFFC is 0x00000000.
